// File: rtl/free_tag_return_queue.sv
// free_tag_return_queue
// Return queue for stale physical register tags between ROB commit and the
// 3-port free list. It accepts up to 3 tags per cycle and compacts them in
// port order. It drains up to min(occupancy, 3, free_space) tags per cycle,
// oldest first, onto the free-list write ports.
//
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   commit_valid_k/tag_k      retiring slot k releases tag_k (k = 0..2)
//   commit_ready              room for a full 3-wide commit (from state only)
//   free_space                empty slots reported by the free list
//   free_en_k/free_tag_k      show-ahead write port k into the free list
//   q_count                   current occupancy
//   overflow_err              sticky: a commit arrived while not ready
module free_tag_return_queue #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned TAG_WIDTH = 6,
    parameter int unsigned CNT_WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     commit_valid_0,
    input  logic                     commit_valid_1,
    input  logic                     commit_valid_2,
    input  logic [TAG_WIDTH-1:0]     commit_tag_0,
    input  logic [TAG_WIDTH-1:0]     commit_tag_1,
    input  logic [TAG_WIDTH-1:0]     commit_tag_2,
    output logic                     commit_ready,
    input  logic [CNT_WIDTH-1:0]     free_space,
    output logic                     free_en_0,
    output logic                     free_en_1,
    output logic                     free_en_2,
    output logic [TAG_WIDTH-1:0]     free_tag_0,
    output logic [TAG_WIDTH-1:0]     free_tag_1,
    output logic [TAG_WIDTH-1:0]     free_tag_2,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     overflow_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned PORTS = 3;

    // Storage and registered state
    logic [TAG_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic                 overflow_q, overflow_d;

    // Per-port views of the commit and free-list ports
    logic [PORTS-1:0]     valid_vec;
    logic [TAG_WIDTH-1:0] tag_in   [PORTS];
    logic [1:0]           slot_ofs [PORTS];
    logic [IDX_W-1:0]     wr_addr  [PORTS];
    logic [IDX_W-1:0]     rd_addr  [PORTS];
    logic [PORTS-1:0]     en_vec;
    logic [TAG_WIDTH-1:0] tag_out  [PORTS];

    logic [PTR_W-1:0]     count;
    logic                 ready;
    logic                 push_ok;
    logic [1:0]           push_cnt;
    logic [1:0]           q_lim;
    logic [1:0]           f_lim;
    logic [1:0]           drain_cnt;

    assign valid_vec = {commit_valid_2, commit_valid_1, commit_valid_0};
    assign tag_in[0] = commit_tag_0;
    assign tag_in[1] = commit_tag_1;
    assign tag_in[2] = commit_tag_2;

    // Occupancy and acceptance, both derived from registered pointers only
    assign count = wr_ptr_q - rd_ptr_q;
    assign ready = (count <= PTR_W'(DEPTH - 3));
    assign push_ok = ready;

    // Compaction: each valid slot lands after the valid slots below it
    always_comb begin
        slot_ofs[0] = 2'd0;
        slot_ofs[1] = 2'(valid_vec[0]);
        slot_ofs[2] = 2'(valid_vec[0]) + 2'(valid_vec[1]);
        push_cnt    = slot_ofs[2] + 2'(valid_vec[2]);
        for (int k = 0; k < int'(PORTS); k++) begin
            wr_addr[k] = wr_ptr_q[IDX_W-1:0] + IDX_W'(slot_ofs[k]);
        end
    end

    // Drain count n = min(count, 3, free_space)
    always_comb begin
        q_lim = (count >= PTR_W'(3)) ? 2'd3 : count[1:0];
        f_lim = (free_space >= CNT_WIDTH'(3)) ? 2'd3 : free_space[1:0];
        drain_cnt = (q_lim < f_lim) ? q_lim : f_lim;
    end

    // Show-ahead read ports; disabled ports present zero
    always_comb begin
        for (int k = 0; k < int'(PORTS); k++) begin
            rd_addr[k] = rd_ptr_q[IDX_W-1:0] + IDX_W'(k);
            en_vec[k]  = (2'(k) < drain_cnt);
            tag_out[k] = en_vec[k] ? mem_q[rd_addr[k]] : '0;
        end
    end

    // Next-state for pointers and the sticky error flag
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push_cnt);
        end else if (|valid_vec) begin
            overflow_d = 1'b1;
        end
        rd_ptr_d = rd_ptr_q + PTR_W'(drain_cnt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; pointers alone define which entries are live
    always_ff @(posedge clk) begin
        if (push_ok) begin
            for (int k = 0; k < int'(PORTS); k++) begin
                if (valid_vec[k]) begin
                    mem_q[wr_addr[k]] <= tag_in[k];
                end
            end
        end
    end

    assign commit_ready = ready;
    assign q_count      = count;
    assign overflow_err = overflow_q;
    assign free_en_0    = en_vec[0];
    assign free_en_1    = en_vec[1];
    assign free_en_2    = en_vec[2];
    assign free_tag_0   = tag_out[0];
    assign free_tag_1   = tag_out[1];
    assign free_tag_2   = tag_out[2];

    // Occupancy bound and no free-list overrun
    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count <= PTR_W'(DEPTH));
    a_no_overrun: assert property (@(posedge clk) disable iff (rst)
        (free_space == '0) |-> (en_vec == '0));

endmodule

// File: tb/tb_free_tag_return_queue.sv
// Directed self-checking bench for free_tag_return_queue (DEPTH=8).
module tb_free_tag_return_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TW    = 6;
    localparam int unsigned CW    = 6;

    logic          clk;
    logic          rst;
    logic          cv0, cv1, cv2;
    logic [TW-1:0] ct0, ct1, ct2;
    logic          commit_ready;
    logic [CW-1:0] free_space;
    logic          fe0, fe1, fe2;
    logic [TW-1:0] ft0, ft1, ft2;
    logic [3:0]    q_count;
    logic          overflow_err;

    int checks = 0;
    int errors = 0;

    free_tag_return_queue #(.DEPTH(DEPTH), .TAG_WIDTH(TW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .commit_valid_0(cv0), .commit_valid_1(cv1), .commit_valid_2(cv2),
        .commit_tag_0(ct0), .commit_tag_1(ct1), .commit_tag_2(ct2),
        .commit_ready(commit_ready), .free_space(free_space),
        .free_en_0(fe0), .free_en_1(fe1), .free_en_2(fe2),
        .free_tag_0(ft0), .free_tag_1(ft1), .free_tag_2(ft2),
        .q_count(q_count), .overflow_err(overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] v, input int t0, input int t1, input int t2);
        {cv2, cv1, cv0} = v;
        ct0 = TW'(t0);
        ct1 = TW'(t1);
        ct2 = TW'(t2);
    endtask

    task automatic check_out(input string tag, input logic [2:0] en, input int t0, input int t1, input int t2);
        check({tag, "_en"}, 32'({fe2, fe1, fe0}), 32'(en));
        check({tag, "_t0"}, 32'(ft0), 32'(t0));
        check({tag, "_t1"}, 32'(ft1), 32'(t1));
        check({tag, "_t2"}, 32'(ft2), 32'(t2));
    endtask

    // Stream-test model state
    int mq[$];
    int sent, received, fs, npush, n, cyc;
    logic [2:0] vexp;
    int texp [3];

    initial begin
        rst = 1'b1;
        drive(3'b000, 0, 0, 0);
        free_space = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_ready", 32'(commit_ready), 1);
        check("rst_count", 32'(q_count), 0);
        check_out("rst_out", 3'b000, 0, 0, 0);
        check("rst_ovf", 32'(overflow_err), 0);
        rst = 1'b0;

        // Compaction: slots 0 and 2 valid
        free_space = CW'(32);
        drive(3'b101, 5, 7, 9);
        #1;
        check_out("cmp_pre", 3'b000, 0, 0, 0);
        step();
        drive(3'b000, 0, 0, 0);
        #1;
        check("cmp_count", 32'(q_count), 2);
        check_out("cmp_out", 3'b011, 5, 9, 0);
        step();
        check("cmp_empty", 32'(q_count), 0);
        check_out("cmp_done", 3'b000, 0, 0, 0);

        // Backpressure: no free space, two full commits
        free_space = '0;
        drive(3'b111, 10, 11, 12);
        step();
        check("bp_count3", 32'(q_count), 3);
        check("bp_ready3", 32'(commit_ready), 1);
        drive(3'b111, 13, 14, 15);
        step();
        drive(3'b000, 0, 0, 0);
        #1;
        check("bp_count6", 32'(q_count), 6);
        check("bp_ready6", 32'(commit_ready), 0);
        check_out("bp_hold", 3'b000, 0, 0, 0);
        free_space = CW'(2);
        #1;
        check_out("bp_d0", 3'b011, 10, 11, 0);
        step();
        check("bp_count4", 32'(q_count), 4);
        check_out("bp_d1", 3'b011, 12, 13, 0);
        step();
        check_out("bp_d2", 3'b011, 14, 15, 0);
        step();
        check("bp_empty", 32'(q_count), 0);

        // Simultaneous push 3 / drain 3 at occupancy 4
        free_space = '0;
        drive(3'b111, 50, 51, 52);
        step();
        drive(3'b001, 53, 0, 0);
        step();
        check("sim_count4", 32'(q_count), 4);
        free_space = CW'(3);
        drive(3'b111, 54, 55, 56);
        #1;
        check("sim_ready", 32'(commit_ready), 1);
        check_out("sim_d0", 3'b111, 50, 51, 52);
        step();
        drive(3'b000, 0, 0, 0);
        #1;
        check("sim_count_after", 32'(q_count), 4);
        check_out("sim_d1", 3'b111, 53, 54, 55);
        step();
        check_out("sim_d2", 3'b001, 56, 0, 0);
        step();
        check("sim_empty", 32'(q_count), 0);

        // Overflow: commit while at occupancy 6 is dropped
        free_space = '0;
        drive(3'b111, 20, 21, 22);
        step();
        drive(3'b111, 23, 24, 25);
        step();
        drive(3'b001, 40, 0, 0);
        step();
        drive(3'b000, 0, 0, 0);
        check("ovf_count", 32'(q_count), 6);
        check("ovf_flag", 32'(overflow_err), 1);
        step();
        check("ovf_sticky", 32'(overflow_err), 1);
        free_space = CW'(3);
        #1;
        check_out("ovf_d0", 3'b111, 20, 21, 22);
        step();
        check_out("ovf_d1", 3'b111, 23, 24, 25);
        step();
        check("ovf_empty", 32'(q_count), 0);
        check("ovf_sticky2", 32'(overflow_err), 1);

        // Wrap: 40 tags, free_space alternating 3/1, against a FIFO model
        sent = 0;
        received = 0;
        cyc = 0;
        while ((sent < 40 || mq.size() != 0) && cyc < 200) begin
            fs = (cyc % 2 == 0) ? 3 : 1;
            npush = 0;
            if (mq.size() <= int'(DEPTH) - 3 && sent < 40) npush = (40 - sent >= 3) ? 3 : 40 - sent;
            free_space = CW'(fs);
            case (npush)
                3: drive(3'b111, sent + 1, sent + 2, sent + 3);
                2: drive(3'b011, sent + 1, sent + 2, 0);
                1: drive(3'b001, sent + 1, 0, 0);
                default: drive(3'b000, 0, 0, 0);
            endcase
            #1;
            n = mq.size();
            if (n > 3) n = 3;
            if (n > fs) n = fs;
            for (int k = 0; k < 3; k++) begin
                vexp[k] = (k < n);
                texp[k] = (k < n) ? mq[k] : 0;
            end
            check("wrap_ready", 32'(commit_ready), 32'(mq.size() <= int'(DEPTH) - 3));
            check("wrap_count", 32'(q_count), 32'(mq.size()));
            check_out("wrap_out", vexp, texp[0], texp[1], texp[2]);
            for (int k = 0; k < n; k++) void'(mq.pop_front());
            received += n;
            for (int k = 0; k < npush; k++) mq.push_back(sent + k + 1);
            sent += npush;
            step();
            cyc++;
        end
        drive(3'b000, 0, 0, 0);
        check("wrap_timeout", 32'(cyc < 200), 1);
        check("wrap_received", 32'(received), 40);
        check("wrap_empty", 32'(q_count), 0);
        check("wrap_ovf", 32'(overflow_err), 1);

        // Reset mid-operation clears queue and outputs asynchronously
        free_space = '0;
        drive(3'b111, 30, 31, 32);
        step();
        drive(3'b000, 0, 0, 0);
        free_space = CW'(3);
        #1;
        check_out("mid_pre", 3'b111, 30, 31, 32);
        #1;
        rst = 1'b1;
        #1;
        check("mid_count", 32'(q_count), 0);
        check_out("mid_out", 3'b000, 0, 0, 0);
        check("mid_ovf", 32'(overflow_err), 0);
        check("mid_ready", 32'(commit_ready), 1);
        rst = 1'b0;
        step();
        check("mid_post", 32'(q_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
